// File: rtl/commit_trace_checker_if.sv
// commit_trace_checker_if
//   Bundles the commit-event capture port, the expected-event stream and the
//   diagnosis outputs of commit_trace_checker.
//   master : the bench / core side (drives events and expected beats)
//   slave  : the checker
//   Ports:
//     ev_valid/ev_data      per-channel commit events, channel i at [i*DATA_W +: DATA_W]
//     exp_valid/ch/data/skip expected-event beat; exp_ready acknowledges it
//     busy, error, err_*     status and latched diagnosis
//     match_cnt              number of successfully compared events
interface commit_trace_checker_if #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 64
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]        ev_valid;
   logic [NUM_CH*DATA_W-1:0] ev_data;
   logic                     exp_valid;
   logic [CH_W-1:0]          exp_ch;
   logic [DATA_W-1:0]        exp_data;
   logic                     exp_skip;
   logic                     exp_ready;
   logic                     busy;
   logic                     error;
   logic [1:0]               err_code;
   logic [CH_W-1:0]          err_ch;
   logic [31:0]              err_cycle;
   logic [DATA_W-1:0]        err_got;
   logic [DATA_W-1:0]        err_exp;
   logic [31:0]              match_cnt;

   modport master (
      output ev_valid, ev_data, exp_valid, exp_ch, exp_data, exp_skip,
      input  exp_ready, busy, error, err_code, err_ch, err_cycle, err_got, err_exp, match_cnt
   );

   modport slave (
      input  ev_valid, ev_data, exp_valid, exp_ch, exp_data, exp_skip,
      output exp_ready, busy, error, err_code, err_ch, err_cycle, err_got, err_exp, match_cnt
   );
endinterface

// File: rtl/commit_trace_checker.sv
// commit_trace_checker
//   Captures per-cycle commit bundles {mask, payloads, cycle stamp} into a FIFO,
//   serialises each bundle's events in ascending channel order and compares
//   them one per cycle against the expected-event stream. Stops in a terminal
//   ERROR state with a latched diagnosis on mismatch, overflow or stall.
//   Ports:
//     clk    core clock
//     rst_n  asynchronous active-low reset
//     clr    synchronous clear, same effect as reset
//     bus    commit_trace_checker_if.slave (events, expected beats, status)
module commit_trace_checker #(
   parameter int NUM_CH     = 3,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   commit_trace_checker_if.slave   bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int SW   = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
   localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_CMP, S_ERR} state_t;

   typedef struct packed {
      logic [NUM_CH-1:0]        mask;
      logic [NUM_CH*DATA_W-1:0] data;
      logic [31:0]              stamp;
   } bundle_t;

   state_t            state_q;
   bundle_t           mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       count_q, count_nx;
   logic [NUM_CH-1:0] done_q;       // bits of the head bundle already consumed
   logic [31:0]       cyc_q;
   logic [SW-1:0]     stall_q, stall_nx;
   logic [31:0]       match_q;
   logic              error_q;
   logic [1:0]        code_q;
   logic [CH_W-1:0]   ech_q;
   logic [31:0]       ecyc_q;
   logic [DATA_W-1:0] egot_q, eexp_q;

   bundle_t           head;
   logic [NUM_CH-1:0] pending, ptr_oh;
   logic [CH_W-1:0]   ptr;
   logic [DATA_W-1:0] cur_data;
   logic              last, busy, exp_rdy, hit, match, mismatch, pop;
   logic              push, full, overflow, do_push, timeout;

   always_comb begin
      head    = mem[rd_q];
      pending = head.mask & ~done_q;
      ptr_oh  = pending & ~(pending - NUM_CH'(1));   // lowest set bit
      ptr     = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (pending[i]) ptr = CH_W'(i);
      cur_data = head.data[int'(ptr)*DATA_W +: DATA_W];
      last     = (pending & ~ptr_oh) == '0;
      busy     = count_q != '0;
      exp_rdy  = (state_q == S_CMP) && bus.exp_valid;
      hit      = (bus.exp_ch == ptr) && (bus.exp_skip || bus.exp_data == cur_data);
      match    = exp_rdy && hit;
      mismatch = exp_rdy && !hit;
      pop      = match && last;
      push     = (state_q != S_ERR) && (bus.ev_valid != '0);
      full     = count_q == DEPTH_C;
      // Full FIFO accepts a new bundle only when the head leaves this cycle.
      overflow = push && full && !pop;
      do_push  = push && (!full || pop) && !mismatch;
      count_nx = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
      stall_nx = '0;
      if (busy && !bus.exp_valid) stall_nx = stall_q + SW'(1);
      timeout  = (state_q != S_ERR) && busy && !bus.exp_valid && (stall_q == STALL_LIM);
   end

   always_ff @(posedge clk)
      if (do_push) mem[wr_q] <= {bus.ev_valid, bus.ev_data, cyc_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE; wr_q <= '0; rd_q <= '0; count_q <= '0; done_q <= '0;
         cyc_q <= '0; stall_q <= '0; match_q <= '0; error_q <= 1'b0; code_q <= '0;
         ech_q <= '0; ecyc_q <= '0; egot_q <= '0; eexp_q <= '0;
      end else if (clr) begin
         state_q <= S_IDLE; wr_q <= '0; rd_q <= '0; count_q <= '0; done_q <= '0;
         cyc_q <= '0; stall_q <= '0; match_q <= '0; error_q <= 1'b0; code_q <= '0;
         ech_q <= '0; ecyc_q <= '0; egot_q <= '0; eexp_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         case (state_q)
            S_ERR: ;   // terminal: everything but the cycle counter holds
            default: begin
               if (do_push) wr_q <= wr_q + AW'(1);
               count_q <= count_nx;
               stall_q <= stall_nx;
               if (match) begin
                  match_q <= match_q + 32'd1;
                  if (last) begin
                     rd_q   <= rd_q + AW'(1);
                     done_q <= '0;
                  end else begin
                     done_q <= done_q | ptr_oh;
                  end
               end
               if (mismatch) begin
                  state_q <= S_ERR; error_q <= 1'b1; code_q <= 2'd1;
                  ech_q <= ptr; ecyc_q <= head.stamp; egot_q <= cur_data; eexp_q <= bus.exp_data;
               end else if (overflow) begin
                  state_q <= S_ERR; error_q <= 1'b1; code_q <= 2'd2;
                  ech_q <= '0; ecyc_q <= cyc_q; egot_q <= '0; eexp_q <= '0;
               end else if (timeout) begin
                  state_q <= S_ERR; error_q <= 1'b1; code_q <= 2'd3;
                  ech_q <= ptr; ecyc_q <= head.stamp; egot_q <= cur_data; eexp_q <= '0;
               end else begin
                  // Enter CMP at the push edge so the head is comparable next cycle.
                  state_q <= (count_nx != '0) ? S_CMP : S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.exp_ready = exp_rdy;
   assign bus.busy      = busy;
   assign bus.error     = error_q;
   assign bus.err_code  = code_q;
   assign bus.err_ch    = ech_q;
   assign bus.err_cycle = ecyc_q;
   assign bus.err_got   = egot_q;
   assign bus.err_exp   = eexp_q;
   assign bus.match_cnt = match_q;
endmodule

// File: tb/tb_commit_trace_checker.sv
module tb_commit_trace_checker;
   localparam int NUM_CH = 3;
   localparam int DATA_W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] tb_cyc;
   logic [31:0] stamp;

   commit_trace_checker_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   commit_trace_checker #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference cycle stamp: counts clock edges since reset/clr.
   always @(posedge clk or negedge rst_n)
      if (!rst_n || clr) tb_cyc <= 32'd0;
      else tb_cyc <= tb_cyc + 32'd1;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic set_ev(input logic [2:0] m, input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
      bus.ev_valid = m;
      bus.ev_data  = {d2, d1, d0};
   endtask

   task automatic set_exp(input logic v, input logic [1:0] ch, input logic [63:0] d, input logic sk);
      bus.exp_valid = v; bus.exp_ch = ch; bus.exp_data = d; bus.exp_skip = sk;
   endtask

   task automatic do_clr();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic test_reset();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      rst_n = 1'b0;
      #12;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %0h exp 0", bus.error); end
      checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0h exp 0", bus.err_code); end
      checks++; if (bus.match_cnt !== 32'd0) begin errors++; $display("FAIL reset_match_cnt got %0h exp 0", bus.match_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
      checks++; if (bus.err_cycle !== 32'd0) begin errors++; $display("FAIL reset_err_cycle got %0h exp 0", bus.err_cycle); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_clr();
      set_ev(3'b001, 64'h0000_0000_0000_0101, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'h0000_0000_0000_0101, 1'b0);
      #1;
      checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL single_idle_ready got %0h exp 0", bus.exp_ready); end
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      #1;
      checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0h exp 1", bus.exp_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", bus.busy); end
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd1) begin errors++; $display("FAIL single_match_cnt got %0h exp 1", bus.match_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %0h exp 0", bus.busy); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL single_error got %0h exp 0", bus.error); end
   endtask

   task automatic test_multi();
      do_clr();
      set_ev(3'b101, 64'h11, 64'h0, 64'h22);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'h11, 1'b0);
      #1;
      checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL multi_ready0 got %0h exp 1", bus.exp_ready); end
      tick();
      set_exp(1'b1, 2'd2, 64'h22, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd1) begin errors++; $display("FAIL multi_cnt1 got %0h exp 1", bus.match_cnt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multi_busy_mid got %0h exp 1", bus.busy); end
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd2) begin errors++; $display("FAIL multi_cnt2 got %0h exp 2", bus.match_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end got %0h exp 0", bus.busy); end
      // wrong order: ch2 offered while ch0 is pending
      do_clr();
      set_ev(3'b101, 64'h11, 64'h0, 64'h22);
      stamp = tb_cyc;
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd2, 64'h22, 1'b0);
      tick();
      #1;
      checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL order_ready_in_err got %0h exp 0", bus.exp_ready); end
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL order_error got %0h exp 1", bus.error); end
      checks++; if (bus.err_code !== 2'd1) begin errors++; $display("FAIL order_code got %0h exp 1", bus.err_code); end
      checks++; if (bus.err_ch !== 2'd0) begin errors++; $display("FAIL order_ch got %0h exp 0", bus.err_ch); end
      checks++; if (bus.err_got !== 64'h11) begin errors++; $display("FAIL order_got got %0h exp 11", bus.err_got); end
      checks++; if (bus.err_exp !== 64'h22) begin errors++; $display("FAIL order_exp got %0h exp 22", bus.err_exp); end
      checks++; if (bus.err_cycle !== stamp) begin errors++; $display("FAIL order_cycle got %0h exp %0h", bus.err_cycle, stamp); end
      checks++; if (bus.match_cnt !== 32'd0) begin errors++; $display("FAIL order_cnt got %0h exp 0", bus.match_cnt); end
   endtask

   task automatic test_skip();
      do_clr();
      set_ev(3'b010, 64'h0, 64'h1234, 64'h0);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd1, 64'hDEAD, 1'b1);
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd1) begin errors++; $display("FAIL skip_cnt got %0h exp 1", bus.match_cnt); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL skip_error got %0h exp 0", bus.error); end
      do_clr();
      set_ev(3'b010, 64'h0, 64'h1234, 64'h0);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'hDEAD, 1'b1);
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.err_code !== 2'd1) begin errors++; $display("FAIL skipch_code got %0h exp 1", bus.err_code); end
      checks++; if (bus.err_ch !== 2'd1) begin errors++; $display("FAIL skipch_ch got %0h exp 1", bus.err_ch); end
      checks++; if (bus.err_got !== 64'h1234) begin errors++; $display("FAIL skipch_got got %0h exp 1234", bus.err_got); end
      checks++; if (bus.err_exp !== 64'hDEAD) begin errors++; $display("FAIL skipch_exp got %0h exp dead", bus.err_exp); end
   endtask

   task automatic test_back_to_back();
      do_clr();
      set_ev(3'b001, 64'hA1, 64'h0, 64'h0);
      tick();
      set_ev(3'b011, 64'hB0, 64'hB1, 64'h0);
      set_exp(1'b1, 2'd0, 64'hA1, 1'b0);
      #1;
      checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0h exp 1", bus.exp_ready); end
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'hB0, 1'b0);
      #1;
      checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0h exp 1", bus.exp_ready); end
      tick();
      set_exp(1'b1, 2'd1, 64'hB1, 1'b0);
      #1;
      checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %0h exp 1", bus.exp_ready); end
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd3) begin errors++; $display("FAIL b2b_cnt got %0h exp 3", bus.match_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0h exp 0", bus.busy); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL b2b_error got %0h exp 0", bus.error); end
   endtask

   task automatic test_overflow();
      do_clr();
      for (int i = 0; i < 9; i++) begin
         set_ev(3'b001, 64'(i + 1), 64'h0, 64'h0);
         if (i == 8) begin
            #1;
            checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL ovf_early got %0h exp 0", bus.error); end
            stamp = tb_cyc;
         end
         tick();
      end
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      #1;
      checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL ovf_error got %0h exp 1", bus.error); end
      checks++; if (bus.err_code !== 2'd2) begin errors++; $display("FAIL ovf_code got %0h exp 2", bus.err_code); end
      checks++; if (bus.err_cycle !== stamp) begin errors++; $display("FAIL ovf_cycle got %0h exp %0h", bus.err_cycle, stamp); end
      checks++; if (bus.err_got !== 64'h0) begin errors++; $display("FAIL ovf_got got %0h exp 0", bus.err_got); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %0h exp 1", bus.busy); end
      // ERROR holds: later beats are refused and the diagnosis stays
      set_exp(1'b1, 2'd0, 64'h1, 1'b0);
      tick(3);
      #1;
      checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL ovf_hold_ready got %0h exp 0", bus.exp_ready); end
      checks++; if (bus.err_code !== 2'd2) begin errors++; $display("FAIL ovf_hold_code got %0h exp 2", bus.err_code); end
      checks++; if (bus.match_cnt !== 32'd0) begin errors++; $display("FAIL ovf_hold_cnt got %0h exp 0", bus.match_cnt); end
   endtask

   task automatic test_timeout();
      do_clr();
      set_ev(3'b100, 64'h0, 64'h0, 64'hABCD);
      stamp = tb_cyc;
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      tick(15);
      #1;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL tmo_15 got %0h exp 0", bus.error); end
      tick();
      #1;
      checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL tmo_16 got %0h exp 1", bus.error); end
      checks++; if (bus.err_code !== 2'd3) begin errors++; $display("FAIL tmo_code got %0h exp 3", bus.err_code); end
      checks++; if (bus.err_got !== 64'hABCD) begin errors++; $display("FAIL tmo_got got %0h exp abcd", bus.err_got); end
      checks++; if (bus.err_ch !== 2'd2) begin errors++; $display("FAIL tmo_ch got %0h exp 2", bus.err_ch); end
      checks++; if (bus.err_cycle !== stamp) begin errors++; $display("FAIL tmo_cycle got %0h exp %0h", bus.err_cycle, stamp); end
      // beat arriving in the 15th stall cycle rescues it
      do_clr();
      set_ev(3'b100, 64'h0, 64'h0, 64'hABCD);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      tick(14);
      set_exp(1'b1, 2'd2, 64'hABCD, 1'b0);
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      tick(4);
      #1;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL tmo_rescue_err got %0h exp 0", bus.error); end
      checks++; if (bus.match_cnt !== 32'd1) begin errors++; $display("FAIL tmo_rescue_cnt got %0h exp 1", bus.match_cnt); end
   endtask

   task automatic test_recovery();
      // force an error, then clear
      do_clr();
      set_ev(3'b001, 64'h5, 64'h0, 64'h0);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'h6, 1'b0);
      tick();
      do_clr();
      #1;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rec_error got %0h exp 0", bus.error); end
      checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL rec_code got %0h exp 0", bus.err_code); end
      checks++; if (bus.err_got !== 64'h0) begin errors++; $display("FAIL rec_got got %0h exp 0", bus.err_got); end
      checks++; if (bus.err_exp !== 64'h0) begin errors++; $display("FAIL rec_exp got %0h exp 0", bus.err_exp); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rec_busy got %0h exp 0", bus.busy); end
      set_ev(3'b001, 64'h77, 64'h0, 64'h0);
      tick();
      set_ev(3'b0, 64'h0, 64'h0, 64'h0);
      set_exp(1'b1, 2'd0, 64'h77, 1'b0);
      tick();
      set_exp(1'b0, 2'd0, 64'h0, 1'b0);
      #1;
      checks++; if (bus.match_cnt !== 32'd1) begin errors++; $display("FAIL rec_cnt got %0h exp 1", bus.match_cnt); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rec_error2 got %0h exp 0", bus.error); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_skip();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_recovery();
      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
